// File: rtl/aidc_path_switch.sv
// AR/AW/W/R/B path switch between the CNN engine, the AIDC compressor and XHB; mode changes only after outstanding traffic drains.
// Optional macro AIDC_PATH_PERF_EN builds handshake counters behind PERF_AR_o / PERF_AW_o (tied to 0 otherwise).
module aidc_path_switch #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RESP_W   = 2,
    parameter int MAX_OUTS = 16
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              ENABLE_i,
    output logic              MODE_o,
    output logic              BUSY_o,
    output logic              ERR_o,
    // CNN engine side
    input  logic              S_AR_VALID_i,
    input  logic [ADDR_W-1:0] S_AR_i,
    output logic              S_AR_READY_o,
    input  logic              S_AW_VALID_i,
    input  logic [ADDR_W-1:0] S_AW_i,
    output logic              S_AW_READY_o,
    input  logic              S_W_VALID_i,
    input  logic [DATA_W-1:0] S_W_i,
    input  logic              S_W_LAST_i,
    output logic              S_W_READY_o,
    output logic              S_R_VALID_o,
    output logic [DATA_W-1:0] S_R_o,
    output logic              S_R_LAST_o,
    input  logic              S_R_READY_i,
    output logic              S_B_VALID_o,
    output logic [RESP_W-1:0] S_B_o,
    input  logic              S_B_READY_i,
    // traffic into AIDC
    output logic              E_AR_VALID_o,
    output logic [ADDR_W-1:0] E_AR_o,
    input  logic              E_AR_READY_i,
    output logic              E_AW_VALID_o,
    output logic [ADDR_W-1:0] E_AW_o,
    input  logic              E_AW_READY_i,
    output logic              E_W_VALID_o,
    output logic [DATA_W-1:0] E_W_o,
    output logic              E_W_LAST_o,
    input  logic              E_W_READY_i,
    output logic              E_R_VALID_o,
    output logic [DATA_W-1:0] E_R_o,
    output logic              E_R_LAST_o,
    input  logic              E_R_READY_i,
    // traffic out of AIDC
    input  logic              C_AR_VALID_i,
    input  logic [ADDR_W-1:0] C_AR_i,
    output logic              C_AR_READY_o,
    input  logic              C_AW_VALID_i,
    input  logic [ADDR_W-1:0] C_AW_i,
    output logic              C_AW_READY_o,
    input  logic              C_W_VALID_i,
    input  logic [DATA_W-1:0] C_W_i,
    input  logic              C_W_LAST_i,
    output logic              C_W_READY_o,
    input  logic              C_R_VALID_i,
    input  logic [DATA_W-1:0] C_R_i,
    input  logic              C_R_LAST_i,
    output logic              C_R_READY_o,
    // XHB side
    output logic              M_AR_VALID_o,
    output logic [ADDR_W-1:0] M_AR_o,
    input  logic              M_AR_READY_i,
    output logic              M_AW_VALID_o,
    output logic [ADDR_W-1:0] M_AW_o,
    input  logic              M_AW_READY_i,
    output logic              M_W_VALID_o,
    output logic [DATA_W-1:0] M_W_o,
    output logic              M_W_LAST_o,
    input  logic              M_W_READY_i,
    input  logic              M_R_VALID_i,
    input  logic [DATA_W-1:0] M_R_i,
    input  logic              M_R_LAST_i,
    output logic              M_R_READY_o,
    input  logic              M_B_VALID_i,
    input  logic [RESP_W-1:0] M_B_i,
    output logic              M_B_READY_o,
    output logic [31:0]       PERF_AR_o,
    output logic [31:0]       PERF_AW_o
);
    localparam int CNT_W = $clog2(MAX_OUTS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    localparam logic [1:0] ST_BYP   = 2'd0;
    localparam logic [1:0] ST_DRN_A = 2'd1;
    localparam logic [1:0] ST_AIDC  = 2'd2;
    localparam logic [1:0] ST_DRN_B = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic             err_q, err_d;
    logic             run_s, route_aidc_s, drain_s, ar_ok_s, aw_ok_s;
    logic             rd_inc_s, rd_dec_s, wr_inc_s, wr_dec_s;

    assign run_s        = ~RST_i;
    assign route_aidc_s = (state_q == ST_AIDC) || (state_q == ST_DRN_B);
    assign drain_s      = (state_q == ST_DRN_A) || (state_q == ST_DRN_B);
    // New addresses stall while draining or when the outstanding budget is full.
    assign ar_ok_s      = run_s & ~drain_s & (rd_cnt_q != CNT_MAX);
    assign aw_ok_s      = run_s & ~drain_s & (wr_cnt_q != CNT_MAX);

    assign MODE_o = route_aidc_s;
    assign BUSY_o = drain_s;
    assign ERR_o  = err_q;

    // Channel routing for the current mode; the engine-side address valid is gated so a stalled address never leaks downstream.
    always_comb begin
        S_AR_READY_o = 1'b0;  S_AW_READY_o = 1'b0;  S_W_READY_o = 1'b0;
        S_R_VALID_o  = 1'b0;  E_AR_VALID_o = 1'b0;  E_AW_VALID_o = 1'b0;
        E_W_VALID_o  = 1'b0;  E_R_VALID_o  = 1'b0;  C_AR_READY_o = 1'b0;
        C_AW_READY_o = 1'b0;  C_W_READY_o  = 1'b0;  C_R_READY_o  = 1'b0;
        M_AR_VALID_o = 1'b0;  M_AW_VALID_o = 1'b0;  M_W_VALID_o  = 1'b0;
        M_R_READY_o  = 1'b0;
        E_AR_o = S_AR_i;  E_AW_o = S_AW_i;  E_W_o = S_W_i;  E_W_LAST_o = S_W_LAST_i;
        E_R_o  = M_R_i;   E_R_LAST_o = M_R_LAST_i;
        M_AR_o = S_AR_i;  M_AW_o = S_AW_i;  M_W_o = S_W_i;  M_W_LAST_o = S_W_LAST_i;
        S_R_o  = M_R_i;   S_R_LAST_o = M_R_LAST_i;
        if (run_s && route_aidc_s) begin
            E_AR_VALID_o = S_AR_VALID_i & ar_ok_s;
            S_AR_READY_o = E_AR_READY_i & ar_ok_s;
            E_AW_VALID_o = S_AW_VALID_i & aw_ok_s;
            S_AW_READY_o = E_AW_READY_i & aw_ok_s;
            E_W_VALID_o  = S_W_VALID_i;
            S_W_READY_o  = E_W_READY_i;
            M_AR_VALID_o = C_AR_VALID_i;  C_AR_READY_o = M_AR_READY_i;  M_AR_o = C_AR_i;
            M_AW_VALID_o = C_AW_VALID_i;  C_AW_READY_o = M_AW_READY_i;  M_AW_o = C_AW_i;
            M_W_VALID_o  = C_W_VALID_i;   C_W_READY_o  = M_W_READY_i;
            M_W_o        = C_W_i;         M_W_LAST_o   = C_W_LAST_i;
            E_R_VALID_o  = M_R_VALID_i;   M_R_READY_o  = E_R_READY_i;
            S_R_VALID_o  = C_R_VALID_i;   C_R_READY_o  = S_R_READY_i;
            S_R_o        = C_R_i;         S_R_LAST_o   = C_R_LAST_i;
        end else if (run_s) begin
            M_AR_VALID_o = S_AR_VALID_i & ar_ok_s;
            S_AR_READY_o = M_AR_READY_i & ar_ok_s;
            M_AW_VALID_o = S_AW_VALID_i & aw_ok_s;
            S_AW_READY_o = M_AW_READY_i & aw_ok_s;
            M_W_VALID_o  = S_W_VALID_i;
            S_W_READY_o  = M_W_READY_i;
            S_R_VALID_o  = M_R_VALID_i;
            M_R_READY_o  = S_R_READY_i;
        end else begin
            S_AR_READY_o = 1'b0;
            S_AW_READY_o = 1'b0;
        end
    end

    assign S_B_VALID_o = M_B_VALID_i & run_s;
    assign M_B_READY_o = S_B_READY_i & run_s;
    assign S_B_o       = M_B_i;

    assign rd_inc_s = S_AR_VALID_i & S_AR_READY_o;
    assign rd_dec_s = S_R_VALID_o & S_R_READY_i & S_R_LAST_o;
    assign wr_inc_s = S_AW_VALID_i & S_AW_READY_o;
    assign wr_dec_s = S_B_VALID_o & S_B_READY_i;

    // Outstanding counters; a response arriving with nothing outstanding is flagged and the counter holds at 0.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        if (rd_inc_s && !rd_dec_s) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
        end else if (!rd_inc_s && rd_dec_s && (rd_cnt_q != CNT_ZERO)) begin
            rd_cnt_d = rd_cnt_q - CNT_ONE;
        end else begin
            rd_cnt_d = rd_cnt_q;
        end
        if (wr_inc_s && !wr_dec_s) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else if (!wr_inc_s && wr_dec_s && (wr_cnt_q != CNT_ZERO)) begin
            wr_cnt_d = wr_cnt_q - CNT_ONE;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        if ((rd_dec_s && (rd_cnt_q == CNT_ZERO)) || (wr_dec_s && (wr_cnt_q == CNT_ZERO))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Mode FSM: drain states wait for both registered counters to read zero before switching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BYP: begin
                if (ENABLE_i) state_d = ST_DRN_A;
                else          state_d = ST_BYP;
            end
            ST_DRN_A: begin
                if (!ENABLE_i)                                          state_d = ST_BYP;
                else if ((rd_cnt_q == CNT_ZERO) && (wr_cnt_q == CNT_ZERO)) state_d = ST_AIDC;
                else                                                    state_d = ST_DRN_A;
            end
            ST_AIDC: begin
                if (!ENABLE_i) state_d = ST_DRN_B;
                else           state_d = ST_AIDC;
            end
            ST_DRN_B: begin
                if (ENABLE_i)                                           state_d = ST_AIDC;
                else if ((rd_cnt_q == CNT_ZERO) && (wr_cnt_q == CNT_ZERO)) state_d = ST_BYP;
                else                                                    state_d = ST_DRN_B;
            end
            default: state_d = ST_BYP;
        endcase
    end

    // State, counter and error registers.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_q  <= ST_BYP;
            rd_cnt_q <= CNT_ZERO;
            wr_cnt_q <= CNT_ZERO;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

`ifdef AIDC_PATH_PERF_EN
    logic [31:0] perf_ar_q, perf_aw_q;

    // Saturating counts of engine address handshakes accepted in AIDC routing.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            perf_ar_q <= 32'd0;
            perf_aw_q <= 32'd0;
        end else begin
            if (rd_inc_s && route_aidc_s && (perf_ar_q != 32'hFFFF_FFFF)) begin
                perf_ar_q <= perf_ar_q + 32'd1;
            end
            if (wr_inc_s && route_aidc_s && (perf_aw_q != 32'hFFFF_FFFF)) begin
                perf_aw_q <= perf_aw_q + 32'd1;
            end
        end
    end

    assign PERF_AR_o = perf_ar_q;
    assign PERF_AW_o = perf_aw_q;
`else
    assign PERF_AR_o = 32'd0;
    assign PERF_AW_o = 32'd0;
`endif

endmodule

// File: tb/tb_aidc_path_switch.sv
// Scoreboard bench for aidc_path_switch: expectations queued at drive time, popped when outputs are sampled.
module tb_aidc_path_switch;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 2;

    logic CLK_i = 1'b0;
    logic RST_i, ENABLE_i, MODE_o, BUSY_o, ERR_o;
    logic S_AR_VALID_i, S_AR_READY_o, S_AW_VALID_i, S_AW_READY_o;
    logic [AW-1:0] S_AR_i, S_AW_i;
    logic S_W_VALID_i, S_W_LAST_i, S_W_READY_o;
    logic [DW-1:0] S_W_i, S_R_o;
    logic S_R_VALID_o, S_R_LAST_o, S_R_READY_i;
    logic S_B_VALID_o, S_B_READY_i;
    logic [RW-1:0] S_B_o, M_B_i;
    logic E_AR_VALID_o, E_AR_READY_i, E_AW_VALID_o, E_AW_READY_i;
    logic [AW-1:0] E_AR_o, E_AW_o, C_AR_i, C_AW_i, M_AR_o, M_AW_o;
    logic E_W_VALID_o, E_W_LAST_o, E_W_READY_i, E_R_VALID_o, E_R_LAST_o, E_R_READY_i;
    logic [DW-1:0] E_W_o, E_R_o, C_W_i, C_R_i, M_W_o, M_R_i;
    logic C_AR_VALID_i, C_AR_READY_o, C_AW_VALID_i, C_AW_READY_o;
    logic C_W_VALID_i, C_W_LAST_i, C_W_READY_o, C_R_VALID_i, C_R_LAST_i, C_R_READY_o;
    logic M_AR_VALID_o, M_AR_READY_i, M_AW_VALID_o, M_AW_READY_i;
    logic M_W_VALID_o, M_W_LAST_o, M_W_READY_i;
    logic M_R_VALID_i, M_R_LAST_i, M_R_READY_o, M_B_VALID_i, M_B_READY_o;
    logic [31:0] PERF_AR_o, PERF_AW_o;

    int err_cnt = 0;
    int chk_cnt = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] perf_ar_exp;

    aidc_path_switch dut (
        .CLK_i(CLK_i), .RST_i(RST_i), .ENABLE_i(ENABLE_i),
        .MODE_o(MODE_o), .BUSY_o(BUSY_o), .ERR_o(ERR_o),
        .S_AR_VALID_i(S_AR_VALID_i), .S_AR_i(S_AR_i), .S_AR_READY_o(S_AR_READY_o),
        .S_AW_VALID_i(S_AW_VALID_i), .S_AW_i(S_AW_i), .S_AW_READY_o(S_AW_READY_o),
        .S_W_VALID_i(S_W_VALID_i), .S_W_i(S_W_i), .S_W_LAST_i(S_W_LAST_i), .S_W_READY_o(S_W_READY_o),
        .S_R_VALID_o(S_R_VALID_o), .S_R_o(S_R_o), .S_R_LAST_o(S_R_LAST_o), .S_R_READY_i(S_R_READY_i),
        .S_B_VALID_o(S_B_VALID_o), .S_B_o(S_B_o), .S_B_READY_i(S_B_READY_i),
        .E_AR_VALID_o(E_AR_VALID_o), .E_AR_o(E_AR_o), .E_AR_READY_i(E_AR_READY_i),
        .E_AW_VALID_o(E_AW_VALID_o), .E_AW_o(E_AW_o), .E_AW_READY_i(E_AW_READY_i),
        .E_W_VALID_o(E_W_VALID_o), .E_W_o(E_W_o), .E_W_LAST_o(E_W_LAST_o), .E_W_READY_i(E_W_READY_i),
        .E_R_VALID_o(E_R_VALID_o), .E_R_o(E_R_o), .E_R_LAST_o(E_R_LAST_o), .E_R_READY_i(E_R_READY_i),
        .C_AR_VALID_i(C_AR_VALID_i), .C_AR_i(C_AR_i), .C_AR_READY_o(C_AR_READY_o),
        .C_AW_VALID_i(C_AW_VALID_i), .C_AW_i(C_AW_i), .C_AW_READY_o(C_AW_READY_o),
        .C_W_VALID_i(C_W_VALID_i), .C_W_i(C_W_i), .C_W_LAST_i(C_W_LAST_i), .C_W_READY_o(C_W_READY_o),
        .C_R_VALID_i(C_R_VALID_i), .C_R_i(C_R_i), .C_R_LAST_i(C_R_LAST_i), .C_R_READY_o(C_R_READY_o),
        .M_AR_VALID_o(M_AR_VALID_o), .M_AR_o(M_AR_o), .M_AR_READY_i(M_AR_READY_i),
        .M_AW_VALID_o(M_AW_VALID_o), .M_AW_o(M_AW_o), .M_AW_READY_i(M_AW_READY_i),
        .M_W_VALID_o(M_W_VALID_o), .M_W_o(M_W_o), .M_W_LAST_o(M_W_LAST_o), .M_W_READY_i(M_W_READY_i),
        .M_R_VALID_i(M_R_VALID_i), .M_R_i(M_R_i), .M_R_LAST_i(M_R_LAST_i), .M_R_READY_o(M_R_READY_o),
        .M_B_VALID_i(M_B_VALID_i), .M_B_i(M_B_i), .M_B_READY_o(M_B_READY_o),
        .PERF_AR_o(PERF_AR_o), .PERF_AW_o(PERF_AW_o)
    );

    always #5 CLK_i = ~CLK_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic exp_pop(input logic [63:0] got);
        if (exp_q.size() == 0) begin
            check_val("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge CLK_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_state(input string tag, input logic mode, input logic busy, input logic err);
        exp_push({tag, "_mode"}, 64'(mode));
        exp_push({tag, "_busy"}, 64'(busy));
        exp_push({tag, "_err"}, 64'(err));
        settle();
        exp_pop(64'(MODE_o));
        exp_pop(64'(BUSY_o));
        exp_pop(64'(ERR_o));
    endtask

    // One bypass AR (or AIDC AR) handshake of the given address.
    task automatic send_ar(input logic [AW-1:0] a);
        S_AR_VALID_i = 1'b1; S_AR_i = a;
        tick();
        S_AR_VALID_i = 1'b0;
    endtask

    task automatic send_r_byp(input logic [DW-1:0] d);
        M_R_VALID_i = 1'b1; M_R_i = d; M_R_LAST_i = 1'b1;
        tick();
        M_R_VALID_i = 1'b0; M_R_LAST_i = 1'b0;
    endtask

    task automatic send_b();
        M_B_VALID_i = 1'b1; M_B_i = 2'b00;
        tick();
        M_B_VALID_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AIDC_PATH_PERF_EN
        perf_ar_exp = 32'd1;
`else
        perf_ar_exp = 32'd0;
`endif
        RST_i = 1'b1; ENABLE_i = 1'b0;
        S_AR_VALID_i = 1'b1; S_AR_i = 32'h0; S_AW_VALID_i = 1'b0; S_AW_i = 32'h0;
        S_W_VALID_i = 1'b0; S_W_i = 32'h0; S_W_LAST_i = 1'b0;
        S_R_READY_i = 1'b1; S_B_READY_i = 1'b1;
        E_AR_READY_i = 1'b1; E_AW_READY_i = 1'b1; E_W_READY_i = 1'b1; E_R_READY_i = 1'b1;
        C_AR_VALID_i = 1'b0; C_AR_i = 32'h0; C_AW_VALID_i = 1'b0; C_AW_i = 32'h0;
        C_W_VALID_i = 1'b0; C_W_i = 32'h0; C_W_LAST_i = 1'b0;
        C_R_VALID_i = 1'b0; C_R_i = 32'h0; C_R_LAST_i = 1'b0;
        M_AR_READY_i = 1'b1; M_AW_READY_i = 1'b1; M_W_READY_i = 1'b1;
        M_R_VALID_i = 1'b0; M_R_i = 32'h0; M_R_LAST_i = 1'b0;
        M_B_VALID_i = 1'b0; M_B_i = 2'b00;

        // Reset: handshake signals held low even with valid/ready asserted.
        exp_push("rst_s_ar_rdy", 64'd0);
        exp_push("rst_m_ar_vld", 64'd0);
        exp_push("rst_m_b_rdy", 64'd0);
        settle();
        exp_pop(64'(S_AR_READY_o));
        exp_pop(64'(M_AR_VALID_o));
        exp_pop(64'(M_B_READY_o));
        tick(); tick();
        S_AR_VALID_i = 1'b0;
        RST_i = 1'b0;
        chk_state("rst", 1'b0, 1'b0, 1'b0);

        // T1: bypass AR, R and W routing.
        tick();
        S_AR_VALID_i = 1'b1; S_AR_i = 32'h100;
        exp_push("t1_m_ar", 64'h100);
        exp_push("t1_m_ar_vld", 64'd1);
        exp_push("t1_e_ar_vld", 64'd0);
        exp_push("t1_s_ar_rdy", 64'd1);
        settle();
        exp_pop(64'(M_AR_o)); exp_pop(64'(M_AR_VALID_o));
        exp_pop(64'(E_AR_VALID_o)); exp_pop(64'(S_AR_READY_o));
        tick();
        S_AR_VALID_i = 1'b0;
        M_R_VALID_i = 1'b1; M_R_i = 32'hA5A5_0001; M_R_LAST_i = 1'b1;
        exp_push("t1_s_r", 64'hA5A5_0001);
        exp_push("t1_s_r_vld", 64'd1);
        exp_push("t1_e_r_vld", 64'd0);
        exp_push("t1_m_r_rdy", 64'd1);
        settle();
        exp_pop(64'(S_R_o)); exp_pop(64'(S_R_VALID_o));
        exp_pop(64'(E_R_VALID_o)); exp_pop(64'(M_R_READY_o));
        tick();
        M_R_VALID_i = 1'b0; M_R_LAST_i = 1'b0;
        S_W_VALID_i = 1'b1; S_W_i = 32'h1234; S_W_LAST_i = 1'b1;
        exp_push("t1_m_w", 64'h1234);
        exp_push("t1_m_w_last", 64'd1);
        exp_push("t1_e_w_vld", 64'd0);
        settle();
        exp_pop(64'(M_W_o)); exp_pop(64'(M_W_LAST_o)); exp_pop(64'(E_W_VALID_o));
        tick();
        S_W_VALID_i = 1'b0; S_W_LAST_i = 1'b0;

        // T2: switch to AIDC with three reads outstanding.
        for (int i = 0; i < 3; i++) send_ar(32'h1000 + 32'(i));
        ENABLE_i = 1'b1;
        tick();
        S_AR_VALID_i = 1'b1; S_AR_i = 32'h999;
        exp_push("t2_s_ar_rdy", 64'd0);
        exp_push("t2_m_ar_vld", 64'd0);
        settle();
        exp_pop(64'(S_AR_READY_o)); exp_pop(64'(M_AR_VALID_o));
        S_AR_VALID_i = 1'b0;
        chk_state("t2_drn", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            M_R_VALID_i = 1'b1; M_R_i = 32'h2000 + 32'(i); M_R_LAST_i = 1'b1;
            exp_push("t2_drn_s_r", 64'(32'h2000 + 32'(i)));
            settle();
            exp_pop(64'(S_R_o));
            tick();
        end
        M_R_VALID_i = 1'b0; M_R_LAST_i = 1'b0;
        chk_state("t2_zero", 1'b0, 1'b1, 1'b0);
        tick();
        chk_state("t2_aidc", 1'b1, 1'b0, 1'b0);

        // AIDC routing of address, write data and read data.
        S_AR_VALID_i = 1'b1; S_AR_i = 32'h200; C_AR_VALID_i = 1'b1; C_AR_i = 32'h300;
        S_W_VALID_i = 1'b1; S_W_i = 32'h55;
        exp_push("a_e_ar", 64'h200);
        exp_push("a_e_ar_vld", 64'd1);
        exp_push("a_m_ar", 64'h300);
        exp_push("a_m_ar_vld", 64'd1);
        exp_push("a_c_ar_rdy", 64'd1);
        exp_push("a_e_w", 64'h55);
        exp_push("a_m_w_vld", 64'd0);
        settle();
        exp_pop(64'(E_AR_o)); exp_pop(64'(E_AR_VALID_o)); exp_pop(64'(M_AR_o));
        exp_pop(64'(M_AR_VALID_o)); exp_pop(64'(C_AR_READY_o));
        exp_pop(64'(E_W_o)); exp_pop(64'(M_W_VALID_o));
        tick();
        S_AR_VALID_i = 1'b0; C_AR_VALID_i = 1'b0; S_W_VALID_i = 1'b0;
        M_R_VALID_i = 1'b1; M_R_i = 32'h77; M_R_LAST_i = 1'b1;
        C_R_VALID_i = 1'b1; C_R_i = 32'h88; C_R_LAST_i = 1'b1;
        exp_push("a_e_r", 64'h77);
        exp_push("a_e_r_vld", 64'd1);
        exp_push("a_s_r", 64'h88);
        exp_push("a_s_r_last", 64'd1);
        exp_push("a_c_r_rdy", 64'd1);
        settle();
        exp_pop(64'(E_R_o)); exp_pop(64'(E_R_VALID_o)); exp_pop(64'(S_R_o));
        exp_pop(64'(S_R_LAST_o)); exp_pop(64'(C_R_READY_o));
        tick();
        M_R_VALID_i = 1'b0; M_R_LAST_i = 1'b0; C_R_VALID_i = 1'b0; C_R_LAST_i = 1'b0;
        ENABLE_i = 1'b0;
        tick();
        chk_state("a_drn_b", 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("a_byp", 1'b0, 1'b0, 1'b0);
        exp_push("perf_ar", 64'(perf_ar_exp));
        exp_push("perf_aw", 64'd0);
        settle();
        exp_pop(64'(PERF_AR_o)); exp_pop(64'(PERF_AW_o));

        // T3: aborted switch with two writes outstanding.
        for (int i = 0; i < 2; i++) begin
            S_AW_VALID_i = 1'b1; S_AW_i = 32'h400 + 32'(i);
            tick();
        end
        S_AW_VALID_i = 1'b0;
        ENABLE_i = 1'b1;
        tick();
        S_AW_VALID_i = 1'b1; S_W_VALID_i = 1'b1;
        exp_push("t3_e_aw_vld", 64'd0);
        exp_push("t3_e_w_vld", 64'd0);
        exp_push("t3_s_aw_rdy", 64'd0);
        settle();
        exp_pop(64'(E_AW_VALID_o)); exp_pop(64'(E_W_VALID_o)); exp_pop(64'(S_AW_READY_o));
        S_AW_VALID_i = 1'b0;
        chk_state("t3_drn", 1'b0, 1'b1, 1'b0);
        tick();
        ENABLE_i = 1'b0;
        tick();
        exp_push("t3_e_w_vld2", 64'd0);
        settle();
        exp_pop(64'(E_W_VALID_o));
        S_W_VALID_i = 1'b0;
        chk_state("t3_byp", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            M_B_VALID_i = 1'b1; M_B_i = 2'(i + 1);
            exp_push("t3_s_b", 64'(i + 1));
            exp_push("t3_s_b_vld", 64'd1);
            settle();
            exp_pop(64'(S_B_o)); exp_pop(64'(S_B_VALID_o));
            tick();
        end
        M_B_VALID_i = 1'b0;

        // T4: write budget saturates at 16 outstanding.
        for (int i = 0; i < 16; i++) begin
            S_AW_VALID_i = 1'b1; S_AW_i = 32'h500 + 32'(i);
            exp_push("t4_s_aw_rdy", 64'd1);
            settle();
            exp_pop(64'(S_AW_READY_o));
            tick();
        end
        exp_push("t4_full_rdy", 64'd0);
        exp_push("t4_full_m_vld", 64'd0);
        settle();
        exp_pop(64'(S_AW_READY_o)); exp_pop(64'(M_AW_VALID_o));
        S_AW_VALID_i = 1'b0;
        send_b();
        S_AW_VALID_i = 1'b1;
        exp_push("t4_rdy_back", 64'd1);
        settle();
        exp_pop(64'(S_AW_READY_o));
        S_AW_VALID_i = 1'b0;
        for (int i = 0; i < 15; i++) send_b();
        chk_state("t4_done", 1'b0, 1'b0, 1'b0);

        // T5: simultaneous AR and R-LAST at rd_cnt=5 leaves it at 5.
        for (int i = 0; i < 5; i++) send_ar(32'h600 + 32'(i));
        S_AR_VALID_i = 1'b1; S_AR_i = 32'h6FF;
        M_R_VALID_i = 1'b1; M_R_LAST_i = 1'b1;
        tick();
        S_AR_VALID_i = 1'b0; M_R_VALID_i = 1'b0; M_R_LAST_i = 1'b0;
        for (int i = 0; i < 5; i++) send_r_byp(32'h700 + 32'(i));
        chk_state("t5_drained", 1'b0, 1'b0, 1'b0);
        ENABLE_i = 1'b1;
        tick(); tick();
        chk_state("t5_aidc", 1'b1, 1'b0, 1'b0);
        ENABLE_i = 1'b0;
        tick(); tick();
        chk_state("t5_byp", 1'b0, 1'b0, 1'b0);

        // T6: stray B sets sticky error; async reset mid-DRN_B clears everything.
        send_b();
        chk_state("t6_err", 1'b0, 1'b0, 1'b1);
        tick(); tick();
        chk_state("t6_err_hold", 1'b0, 1'b0, 1'b1);
        ENABLE_i = 1'b1;
        tick(); tick();
        S_AW_VALID_i = 1'b1; S_AW_i = 32'h800;
        tick();
        S_AW_VALID_i = 1'b0;
        ENABLE_i = 1'b0;
        tick(); tick();
        chk_state("t6_drn_b", 1'b1, 1'b1, 1'b1);
        RST_i = 1'b1;
        S_AW_VALID_i = 1'b1;
        #1;
        exp_push("t6_rst_mode", 64'd0);
        exp_push("t6_rst_busy", 64'd0);
        exp_push("t6_rst_err", 64'd0);
        exp_push("t6_rst_aw_rdy", 64'd0);
        exp_push("t6_rst_perf_aw", 64'd0);
        exp_pop(64'(MODE_o)); exp_pop(64'(BUSY_o)); exp_pop(64'(ERR_o));
        exp_pop(64'(S_AW_READY_o)); exp_pop(64'(PERF_AW_o));
        S_AW_VALID_i = 1'b0;
        tick();
        RST_i = 1'b0;
        tick();
        chk_state("t6_after", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
